// File: rtl/spi_fsm.sv
// spi_fsm: SPI slave transaction controller behind the SCLK/CS conditioners and shift register.
// Latency: addrWe 1 clk after the last command posedge, srWe 2 clk after it (3 with READ_WAIT), dmWe 1 clk after the last data posedge.
// Backpressure: none; SCLK edges are consumed as they arrive and CS high aborts any frame.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   reset        asynchronous active-high reset
//   sclkPosEdge  one-clk pulse per SCLK rising edge
//   sclkNegEdge  one-clk pulse per SCLK falling edge
//   chipSelect   conditioned CS, active low (1 = bus idle)
//   rwBit        shift-register parallelDataOut[0], 1 = read, 0 = write
//   addrWe       address-latch write enable, one-clk pulse
//   srWe         shift-register parallelLoad, one-clk pulse
//   dmWe         data-memory write enable, one-clk pulse
//   misoBufe     MISO tri-state enable, high through the read data phase
//
// Build option: define SPI_FSM_READ_WAIT_EN to insert one idle clk between the
// address latch and the shift-register load, for a registered data memory.
module spi_fsm #(
  parameter int CMD_BITS  = 8,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic chipSelect,
  input  logic rwBit,
  output logic addrWe,
  output logic srWe,
  output logic dmWe,
  output logic misoBufe
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    GET_CMD     = 4'd1,
    LATCH_ADDR  = 4'd2,
    READ_WAIT   = 4'd3,
    READ_LOAD   = 4'd4,
    READ_SEND   = 4'd5,
    WRITE_GET   = 4'd6,
    WRITE_STORE = 4'd7,
    DONE        = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             addr_we_q, sr_we_q, dm_we_q, miso_bufe_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // CS release aborts the frame and wins over any edge seen in the same clk.
    if (chipSelect && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!chipSelect) begin
            state_d = GET_CMD;
            cnt_d   = '0;
          end
        end
        GET_CMD: begin
          if (sclkPosEdge) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CMD_LAST) state_d = LATCH_ADDR;
          end
        end
        LATCH_ADDR: begin
          // rwBit is the last command bit, settled in the shift register by now.
          if (rwBit) begin
`ifdef SPI_FSM_READ_WAIT_EN
            state_d = READ_WAIT;
`else
            state_d = READ_LOAD;
`endif
          end else begin
            state_d = WRITE_GET;
            cnt_d   = '0;
          end
        end
        READ_WAIT: state_d = READ_LOAD;
        READ_LOAD: begin
          state_d = READ_SEND;
          cnt_d   = '0;
        end
        READ_SEND: begin
          // Read data is shifted out on SCLK falling edges; rising edges are ignored here.
          if (sclkNegEdge) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DATA_LAST) state_d = DONE;
          end
        end
        WRITE_GET: begin
          if (sclkPosEdge) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DATA_LAST) state_d = WRITE_STORE;
          end
        end
        WRITE_STORE: state_d = DONE;
        DONE:        state_d = DONE;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each strobe is high in exactly
  // the clk cycles the registered state occupies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_bufe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_we_q   <= (state_d == LATCH_ADDR);
      sr_we_q     <= (state_d == READ_LOAD);
      dm_we_q     <= (state_d == WRITE_STORE);
      miso_bufe_q <= (state_d == READ_SEND);
    end
  end

  assign addrWe   = addr_we_q;
  assign srWe     = sr_we_q;
  assign dmWe     = dm_we_q;
  assign misoBufe = miso_bufe_q;

endmodule

// File: tb/tb_spi_fsm.sv
`timescale 1ns/1ps
module tb_spi_fsm;

  logic clk = 1'b0;
  logic reset, pos, neg, cs, rw;
  logic addrWe, srWe, dmWe, misoBufe;

  spi_fsm #(.CMD_BITS(8), .DATA_BITS(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclkPosEdge(pos),
    .sclkNegEdge(neg),
    .chipSelect (cs),
    .rwBit      (rw),
    .addrWe     (addrWe),
    .srWe       (srWe),
    .dmWe       (dmWe),
    .misoBufe   (misoBufe)
  );

  always #5 clk = ~clk;

`ifdef SPI_FSM_READ_WAIT_EN
  localparam int RW_EXTRA = 1;
`else
  localparam int RW_EXTRA = 0;
`endif

  localparam int EV_ADDR = 0, EV_SR = 1, EV_DM = 2, EV_MRISE = 3, EV_MFALL = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_addr = 0;
  int   n_dm = 0;
  logic miso_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Pop the next expected event and compare it with the one just observed.
  task automatic observe(input int kind);
    ev_t e;
    check_eq($sformatf("ev_pending(kind %0d)", kind), 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("ev_kind", 32'(kind), 32'(e.kind));
      check_eq($sformatf("ev_cycle(kind %0d)", kind), 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Drive one clk of inputs, then sample the outputs just after the edge.
  task automatic step(input logic p, input logic n, input logic c);
    int s;
    pos = p;
    neg = n;
    cs  = c;
    @(posedge clk);
    #1;
    cyc++;
    s = int'(addrWe) + int'(srWe) + int'(dmWe);
    check_eq("strobe_onehot", 32'(s <= 1), 32'd1);
    if (addrWe) begin observe(EV_ADDR); n_addr++; end
    if (srWe) observe(EV_SR);
    if (dmWe) begin observe(EV_DM); n_dm++; end
    if (misoBufe && !miso_prev) observe(EV_MRISE);
    if (!misoBufe && miso_prev) observe(EV_MFALL);
    miso_prev = misoBufe;
  endtask

  task automatic start_frame();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_cmd(input logic r, input logic collide);
    rw = r;
    for (int i = 0; i < 8; i++) begin
      if (!collide) step(1'b0, 1'b1, 1'b0);
      if (i == 7) begin
        expect_ev(EV_ADDR, cyc + 1);
        if (r) begin
          expect_ev(EV_SR, cyc + 2 + RW_EXTRA);
          expect_ev(EV_MRISE, cyc + 3 + RW_EXTRA);
        end
      end
      step(1'b1, collide, 1'b0);
    end
  endtask

  task automatic write_data(input int nbits);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 7) expect_ev(EV_DM, cyc + 1);
      step(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic read_data(input logic collide);
    repeat (2 + RW_EXTRA) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (!collide) step(1'b1, 1'b0, 1'b0);
      if (i == 7) expect_ev(EV_MFALL, cyc + 1);
      step(collide, 1'b1, 1'b0);
    end
  endtask

  // Edges in DONE must produce nothing; then a single clk of CS high.
  task automatic end_frame();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("done_quiet", 32'({addrWe, srWe, dmWe, misoBufe}), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_outs", 32'({addrWe, srWe, dmWe, misoBufe}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    miso_prev = 1'b0;
    rw = 1'b0;
  endtask

  int a0, d0;

  initial begin
    reset = 1'b1;
    pos = 1'b0;
    neg = 1'b0;
    cs  = 1'b1;
    rw  = 1'b0;
    #3;
    check_eq("reset_outs", 32'({addrWe, srWe, dmWe, misoBufe}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check_eq("idle_outs", 32'({addrWe, srWe, dmWe, misoBufe}), 32'd0);

    // Reset in GET_CMD after three edges; the next frame must count from zero.
    start_frame();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    pulse_reset();
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(8);
    end_frame();

    // Reset in the middle of the read data phase drops misoBufe without a clk.
    start_frame();
    send_cmd(1'b1, 1'b0);
    repeat (2 + RW_EXTRA) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check_eq("miso_before_reset", 32'(misoBufe), 32'd1);
    pulse_reset();
    check_eq("q_drained_rst", 32'(exp_q.size()), 32'd0);

    // Plain write and read frames.
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(8);
    end_frame();
    start_frame();
    send_cmd(1'b1, 1'b0);
    read_data(1'b0);
    end_frame();

    // Abort after 12 posedges total, with an edge in the aborting clk.
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(4);
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    // Abort coinciding with the final data edge must still not write.
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(7);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check_eq("q_drained_abort", 32'(exp_q.size()), 32'd0);
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(8);
    end_frame();

    // Simultaneous edge pulses count once in GET_CMD and in READ_SEND.
    start_frame();
    send_cmd(1'b1, 1'b1);
    read_data(1'b1);
    end_frame();

    // Back-to-back writes separated by one clk of CS high.
    a0 = n_addr;
    d0 = n_dm;
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(8);
    end_frame();
    start_frame();
    send_cmd(1'b0, 1'b0);
    write_data(8);
    end_frame();
    check_eq("b2b_addrWe_pulses", 32'(n_addr - a0), 32'd2);
    check_eq("b2b_dmWe_pulses", 32'(n_dm - d0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
